ctrl_unit: RTL and testbench
============================

# ctrl_unit

Main decoder for the RV32IM core's decode stage. Turns the opcode, funct3 and funct7 bits 5 and 0 of the fetched instruction into datapath control: register write, result mux, memory write, jump/branch, ALU operation, ALU operand-B select and immediate format. Outputs are registered so they align with the decode→execute pipeline register; reset drives a bubble (no architectural side effects).

## Interface
Parameters: none.
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- funct7b0  in  1  instr[25] (M-extension select)
- RegWrite  out  1  write rd
- ResultSrc  out  2  00 ALU, 01 memory, 10 immediate, 11 PC+4
- MemWrite  out  1  store
- Jump  out  1  unconditional PC redirect
- Branch  out  1  conditional branch
- ALUControl  out  5  ALU operation code
- ALUSrc  out  1  0 = rs2, 1 = immediate for operand B
- ImmSrc  out  3  000 U, 001 J, 010 B, 011 S, 100 I, 101 I-shamt

## Operation
- ALUControl = {funct3, alt, m}: alt selects SUB/SRA, m selects the M-extension operation. 11111 means illegal/unsupported.
- R-type 0110011:
  - RegWrite=1, ResultSrc=00, ALUSrc=0, ImmSrc=100.
  - ALUControl={funct3,funct7b5,funct7b0}.
  - funct7b5&funct7b0 both set → illegal.
- I-ALU 0010011:
  - RegWrite=1, ResultSrc=00, ALUSrc=1.
  - ImmSrc=101 for funct3 001/101, else 100.
  - ALUControl={funct3,(funct3==101)&funct7b5,0}. ADDI never subtracts.
- Load 0000011: RegWrite=1, ResultSrc=01, ALUSrc=1, ImmSrc=100, ALUControl=00000.
- Store 0100011: MemWrite=1, ALUSrc=1, ImmSrc=011, ALUControl=00000.
- Branch 1100011: Branch=1, ALUSrc=0, ImmSrc=010.
  - ALUControl by funct3:
    - BEQ/BNE: 00010 (SUB).
    - BLT/BGE: 01000 (SLT).
    - BLTU/BGEU: 01100 (SLTU).
    - 010/011: illegal.
- JAL 1101111: RegWrite=1, ResultSrc=11, Jump=1, ALUSrc=0, ImmSrc=001, ALUControl=00000.
- JALR 1100111: as JAL but ALUSrc=1, ImmSrc=100.
- LUI 0110111: RegWrite=1, ResultSrc=10, ALUSrc=0, ImmSrc=000, ALUControl=00000.
- AUIPC 0010111: RegWrite=1, ResultSrc=00, ALUSrc=1, ImmSrc=000, ALUControl=00000. The PC operand A select is handled outside this block.
- Any other opcode, or an illegal combination within a valid opcode:
  - RegWrite=MemWrite=Jump=Branch=ALUSrc=0, ResultSrc=00, ImmSrc=100, ALUControl=11111.
- Signals not listed for an opcode are 0.

## Timing
- Decode is combinational from the inputs; every output is registered. Latency is 1 cycle: the inputs present before edge N appear on the outputs after edge N.
- rst_n low drives all outputs to 0 immediately (asynchronously): ALUControl=00000, ImmSrc=000, ResultSrc=00. The outputs hold 0 while rst_n is low.
- Inputs are sampled on the first rising edge after deassertion.
- Reset asserted mid-stream discards the pending decode; no partial update occurs.
- No handshake and no stall input. A new decode is produced every cycle.

## Structure
- Shared package `rv32_pkg`:
  - opcode constants: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC.
  - ImmSrc codes.
  - ResultSrc codes.
  - ALUControl codes, including ALU_ILLEGAL=5'b11111.
- One combinational sub-module, `alu_decoder`: inputs are opcode class, funct3, funct7b5, funct7b0; output is ALUControl.
- The main decoder and the output register stay in ctrl_unit.

## Test plan
- Reset: hold rst_n=0 with R-type inputs applied → all outputs 0. Release, then clock ADD (0110011/000/0/0) → RegWrite=1, ResultSrc=00, ALUControl=00000, ALUSrc=0, ImmSrc=100.
- Arithmetic decodes, one cycle after each edge:
  - MUL (f7b0=1) → 00001.
  - SUB (f7b5=1) → 00010.
  - SRAI (0010011/101/f7b5=1) → ALUControl=10110, ALUSrc=1, ImmSrc=101.
- Memory and branch:
  - LW (0000011/010) → ResultSrc=01, ALUSrc=1, ImmSrc=100.
  - SW (0100011/010) → MemWrite=1, RegWrite=0, ImmSrc=011.
  - BEQ → Branch=1, ALUControl=00010, ImmSrc=010.
  - BLTU → ALUControl=01100.
- Jumps and upper immediates:
  - JAL → Jump=1, ResultSrc=11, ImmSrc=001, ALUSrc=0.
  - JALR → ALUSrc=1, ImmSrc=100.
  - LUI → ResultSrc=10, ImmSrc=000, ALUSrc=0.
  - AUIPC → ResultSrc=00, ALUSrc=1, ImmSrc=000.
- Illegal: opcode 1111111 → all controls 0, ALUControl=11111, ImmSrc=100. R-type with f7b5=f7b0=1 → same.
- Async reset mid-stream: assert rst_n between edges while decoding JAL → outputs clear before the next edge. Check latency alignment with a back-to-back instruction stream.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32IM decode definitions: opcodes, control-field encodings and the
// opcode classifier used by the decode-stage control logic.
package rv32_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_U      = 3'b000;
  localparam logic [2:0] IMM_J      = 3'b001;
  localparam logic [2:0] IMM_B      = 3'b010;
  localparam logic [2:0] IMM_S      = 3'b011;
  localparam logic [2:0] IMM_I      = 3'b100;
  localparam logic [2:0] IMM_ISHAMT = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_IMM = 2'b10;
  localparam logic [1:0] RES_PC4 = 2'b11;

  localparam logic [4:0] ALU_ADD     = 5'b00000;
  localparam logic [4:0] ALU_SUB     = 5'b00010;
  localparam logic [4:0] ALU_SLT     = 5'b01000;
  localparam logic [4:0] ALU_SLTU    = 5'b01100;
  localparam logic [4:0] ALU_ILLEGAL = 5'b11111;

  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_ILLEGAL
  } op_class_e;

  function automatic op_class_e classify(input logic [6:0] opcode);
    case (opcode)
      OP_R:      return CLS_R;
      OP_I:      return CLS_I;
      OP_LOAD:   return CLS_LOAD;
      OP_STORE:  return CLS_STORE;
      OP_BRANCH: return CLS_BRANCH;
      OP_JAL:    return CLS_JAL;
      OP_JALR:   return CLS_JALR;
      OP_LUI:    return CLS_LUI;
      OP_AUIPC:  return CLS_AUIPC;
      default:   return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU-operation decoder; ALUControl = {funct3, alt, m}, with
// ALU_ILLEGAL flagging any unsupported encoding.
module alu_decoder
  import rv32_pkg::*;
(
  input  logic [3:0] op_class,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       funct7b0,
  output logic [4:0] alu_control
);

  always_comb begin
    alu_control = ALU_ILLEGAL;
    case (op_class_e'(op_class))
      CLS_R: begin
        if (!(funct7b5 && funct7b0))
          alu_control = {funct3, funct7b5, funct7b0};
      end
      // Only SRAI uses the alt bit; ADDI with instr[30] set is still an add.
      CLS_I:      alu_control = {funct3, (funct3 == 3'b101) && funct7b5, 1'b0};
      CLS_BRANCH: begin
        case (funct3)
          3'b000, 3'b001: alu_control = ALU_SUB;
          3'b100, 3'b101: alu_control = ALU_SLT;
          3'b110, 3'b111: alu_control = ALU_SLTU;
          default:        alu_control = ALU_ILLEGAL;
        endcase
      end
      CLS_LOAD, CLS_STORE, CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC:
        alu_control = ALU_ADD;
      default: alu_control = ALU_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/ctrl_unit.sv
// Decode-stage main decoder for the RV32IM core. Control fields are decoded
// combinationally and registered to line up with the decode->execute register.
module ctrl_unit
  import rv32_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       funct7b0,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic       MemWrite,
  output logic       Jump,
  output logic       Branch,
  output logic [4:0] ALUControl,
  output logic       ALUSrc,
  output logic [2:0] ImmSrc
);

  op_class_e  cls_p0;
  logic [4:0] alu_ctl_p0;
  logic       reg_write_p0;
  logic [1:0] result_src_p0;
  logic       mem_write_p0;
  logic       jump_p0;
  logic       branch_p0;
  logic       alu_src_p0;
  logic [2:0] imm_src_p0;

  assign cls_p0 = classify(opcode);

  alu_decoder u_alu_decoder (
    .op_class    (cls_p0),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .funct7b0    (funct7b0),
    .alu_control (alu_ctl_p0)
  );

  always_comb begin
    reg_write_p0  = 1'b0;
    result_src_p0 = RES_ALU;
    mem_write_p0  = 1'b0;
    jump_p0       = 1'b0;
    branch_p0     = 1'b0;
    alu_src_p0    = 1'b0;
    imm_src_p0    = IMM_I;
    case (cls_p0)
      CLS_R:      reg_write_p0 = 1'b1;
      CLS_I: begin
        reg_write_p0 = 1'b1;
        alu_src_p0   = 1'b1;
        if (funct3 == 3'b001 || funct3 == 3'b101) imm_src_p0 = IMM_ISHAMT;
      end
      CLS_LOAD: begin
        reg_write_p0  = 1'b1;
        result_src_p0 = RES_MEM;
        alu_src_p0    = 1'b1;
      end
      CLS_STORE: begin
        mem_write_p0 = 1'b1;
        alu_src_p0   = 1'b1;
        imm_src_p0   = IMM_S;
      end
      CLS_BRANCH: begin
        branch_p0  = 1'b1;
        imm_src_p0 = IMM_B;
      end
      CLS_JAL: begin
        reg_write_p0  = 1'b1;
        result_src_p0 = RES_PC4;
        jump_p0       = 1'b1;
        imm_src_p0    = IMM_J;
      end
      CLS_JALR: begin
        reg_write_p0  = 1'b1;
        result_src_p0 = RES_PC4;
        jump_p0       = 1'b1;
        alu_src_p0    = 1'b1;
      end
      CLS_LUI: begin
        reg_write_p0  = 1'b1;
        result_src_p0 = RES_IMM;
        imm_src_p0    = IMM_U;
      end
      CLS_AUIPC: begin
        reg_write_p0 = 1'b1;
        alu_src_p0   = 1'b1;
        imm_src_p0   = IMM_U;
      end
      default: ;
    endcase
    // An illegal funct combination inside a valid opcode must not cause side effects.
    if (alu_ctl_p0 == ALU_ILLEGAL) begin
      reg_write_p0  = 1'b0;
      result_src_p0 = RES_ALU;
      mem_write_p0  = 1'b0;
      jump_p0       = 1'b0;
      branch_p0     = 1'b0;
      alu_src_p0    = 1'b0;
      imm_src_p0    = IMM_I;
    end
  end

  // p0 -> p1: decode/execute boundary register; reset leaves a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite   <= 1'b0;
      ResultSrc  <= 2'b00;
      MemWrite   <= 1'b0;
      Jump       <= 1'b0;
      Branch     <= 1'b0;
      ALUControl <= 5'b00000;
      ALUSrc     <= 1'b0;
      ImmSrc     <= 3'b000;
    end else begin
      RegWrite   <= reg_write_p0;
      ResultSrc  <= result_src_p0;
      MemWrite   <= mem_write_p0;
      Jump       <= jump_p0;
      Branch     <= branch_p0;
      ALUControl <= alu_ctl_p0;
      ALUSrc     <= alu_src_p0;
      ImmSrc     <= imm_src_p0;
    end
  end

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed bench for ctrl_unit: hand-computed control words per instruction,
// async reset behaviour and one-cycle latency on a back-to-back stream.
module tb_ctrl_unit;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       funct7b0;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic       MemWrite;
  logic       Jump;
  logic       Branch;
  logic [4:0] ALUControl;
  logic       ALUSrc;
  logic [2:0] ImmSrc;

  int n_tests;
  int n_fail;

  ctrl_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .funct7b0   (funct7b0),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .MemWrite   (MemWrite),
    .Jump       (Jump),
    .Branch     (Branch),
    .ALUControl (ALUControl),
    .ALUSrc     (ALUSrc),
    .ImmSrc     (ImmSrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_ctrl(input string tag, input logic rw, input logic [1:0] rs,
                            input logic mw, input logic j, input logic b,
                            input logic [4:0] alu, input logic asrc, input logic [2:0] imm);
    check({tag, ".RegWrite"},   32'(RegWrite),   32'(rw));
    check({tag, ".ResultSrc"},  32'(ResultSrc),  32'(rs));
    check({tag, ".MemWrite"},   32'(MemWrite),   32'(mw));
    check({tag, ".Jump"},       32'(Jump),       32'(j));
    check({tag, ".Branch"},     32'(Branch),     32'(b));
    check({tag, ".ALUControl"}, 32'(ALUControl), 32'(alu));
    check({tag, ".ALUSrc"},     32'(ALUSrc),     32'(asrc));
    check({tag, ".ImmSrc"},     32'(ImmSrc),     32'(imm));
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic b5, input logic b0);
    opcode   = op;
    funct3   = f3;
    funct7b5 = b5;
    funct7b0 = b0;
  endtask

  // Apply an instruction, clock it in and sample 1 time unit after the edge.
  task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic b5, input logic b0);
    drive(op, f3, b5, b0);
    @(posedge clk);
    #1;
  endtask

  logic [6:0] s_op  [8];
  logic [2:0] s_f3  [8];
  logic       s_b5  [8];
  logic       s_b0  [8];
  logic [4:0] s_alu [8];
  logic       s_rw  [8];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive(7'b0110011, 3'b000, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check_ctrl("reset_hold", 0, 2'b00, 0, 0, 0, 5'b00000, 0, 3'b000);

    @(negedge clk);
    rst_n = 1'b1;
    step(7'b0110011, 3'b000, 1'b0, 1'b0);
    check_ctrl("add",   1, 2'b00, 0, 0, 0, 5'b00000, 0, 3'b100);

    step(7'b0110011, 3'b000, 1'b0, 1'b1);
    check_ctrl("mul",   1, 2'b00, 0, 0, 0, 5'b00001, 0, 3'b100);
    step(7'b0110011, 3'b000, 1'b1, 1'b0);
    check_ctrl("sub",   1, 2'b00, 0, 0, 0, 5'b00010, 0, 3'b100);
    step(7'b0110011, 3'b101, 1'b1, 1'b0);
    check_ctrl("sra",   1, 2'b00, 0, 0, 0, 5'b10110, 0, 3'b100);
    step(7'b0110011, 3'b101, 1'b0, 1'b1);
    check_ctrl("divu",  1, 2'b00, 0, 0, 0, 5'b10101, 0, 3'b100);
    step(7'b0010011, 3'b101, 1'b1, 1'b0);
    check_ctrl("srai",  1, 2'b00, 0, 0, 0, 5'b10110, 1, 3'b101);
    step(7'b0010011, 3'b000, 1'b1, 1'b0);
    check_ctrl("addi_b5", 1, 2'b00, 0, 0, 0, 5'b00000, 1, 3'b100);
    step(7'b0010011, 3'b001, 1'b0, 1'b0);
    check_ctrl("slli",  1, 2'b00, 0, 0, 0, 5'b00100, 1, 3'b101);
    step(7'b0010011, 3'b110, 1'b1, 1'b0);
    check_ctrl("ori_b5", 1, 2'b00, 0, 0, 0, 5'b11000, 1, 3'b100);

    step(7'b0000011, 3'b010, 1'b0, 1'b0);
    check_ctrl("lw",    1, 2'b01, 0, 0, 0, 5'b00000, 1, 3'b100);
    step(7'b0100011, 3'b010, 1'b0, 1'b0);
    check_ctrl("sw",    0, 2'b00, 1, 0, 0, 5'b00000, 1, 3'b011);
    step(7'b1100011, 3'b000, 1'b0, 1'b0);
    check_ctrl("beq",   0, 2'b00, 0, 0, 1, 5'b00010, 0, 3'b010);
    step(7'b1100011, 3'b001, 1'b0, 1'b0);
    check_ctrl("bne",   0, 2'b00, 0, 0, 1, 5'b00010, 0, 3'b010);
    step(7'b1100011, 3'b100, 1'b0, 1'b0);
    check_ctrl("blt",   0, 2'b00, 0, 0, 1, 5'b01000, 0, 3'b010);
    step(7'b1100011, 3'b101, 1'b0, 1'b0);
    check_ctrl("bge",   0, 2'b00, 0, 0, 1, 5'b01000, 0, 3'b010);
    step(7'b1100011, 3'b110, 1'b0, 1'b0);
    check_ctrl("bltu",  0, 2'b00, 0, 0, 1, 5'b01100, 0, 3'b010);
    step(7'b1100011, 3'b111, 1'b0, 1'b0);
    check_ctrl("bgeu",  0, 2'b00, 0, 0, 1, 5'b01100, 0, 3'b010);
    step(7'b1100011, 3'b010, 1'b0, 1'b0);
    check_ctrl("br_ill", 0, 2'b00, 0, 0, 0, 5'b11111, 0, 3'b100);

    step(7'b1101111, 3'b000, 1'b0, 1'b0);
    check_ctrl("jal",   1, 2'b11, 0, 1, 0, 5'b00000, 0, 3'b001);
    step(7'b1100111, 3'b000, 1'b0, 1'b0);
    check_ctrl("jalr",  1, 2'b11, 0, 1, 0, 5'b00000, 1, 3'b100);
    step(7'b0110111, 3'b000, 1'b0, 1'b0);
    check_ctrl("lui",   1, 2'b10, 0, 0, 0, 5'b00000, 0, 3'b000);
    step(7'b0010111, 3'b000, 1'b0, 1'b0);
    check_ctrl("auipc", 1, 2'b00, 0, 0, 0, 5'b00000, 1, 3'b000);

    step(7'b1111111, 3'b000, 1'b0, 1'b0);
    check_ctrl("op_ill", 0, 2'b00, 0, 0, 0, 5'b11111, 0, 3'b100);
    step(7'b0110011, 3'b000, 1'b1, 1'b1);
    check_ctrl("r_ill",  0, 2'b00, 0, 0, 0, 5'b11111, 0, 3'b100);

    step(7'b1101111, 3'b000, 1'b0, 1'b0);
    check_ctrl("jal_pre", 1, 2'b11, 0, 1, 0, 5'b00000, 0, 3'b001);
    #2;
    rst_n = 1'b0;
    #1;
    check_ctrl("async_rst", 0, 2'b00, 0, 0, 0, 5'b00000, 0, 3'b000);
    @(posedge clk);
    #1;
    check_ctrl("rst_edge", 0, 2'b00, 0, 0, 0, 5'b00000, 0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    step(7'b1101111, 3'b000, 1'b0, 1'b0);
    check_ctrl("jal_post", 1, 2'b11, 0, 1, 0, 5'b00000, 0, 3'b001);

    s_op[0] = 7'b0110011; s_f3[0] = 3'b000; s_b5[0] = 1'b0; s_b0[0] = 1'b0; s_alu[0] = 5'b00000; s_rw[0] = 1'b1;
    s_op[1] = 7'b0110011; s_f3[1] = 3'b000; s_b5[1] = 1'b1; s_b0[1] = 1'b0; s_alu[1] = 5'b00010; s_rw[1] = 1'b1;
    s_op[2] = 7'b0000011; s_f3[2] = 3'b010; s_b5[2] = 1'b0; s_b0[2] = 1'b0; s_alu[2] = 5'b00000; s_rw[2] = 1'b1;
    s_op[3] = 7'b1100011; s_f3[3] = 3'b110; s_b5[3] = 1'b0; s_b0[3] = 1'b0; s_alu[3] = 5'b01100; s_rw[3] = 1'b0;
    s_op[4] = 7'b1101111; s_f3[4] = 3'b000; s_b5[4] = 1'b0; s_b0[4] = 1'b0; s_alu[4] = 5'b00000; s_rw[4] = 1'b1;
    s_op[5] = 7'b1111111; s_f3[5] = 3'b000; s_b5[5] = 1'b0; s_b0[5] = 1'b0; s_alu[5] = 5'b11111; s_rw[5] = 1'b0;
    s_op[6] = 7'b0110011; s_f3[6] = 3'b100; s_b5[6] = 1'b0; s_b0[6] = 1'b1; s_alu[6] = 5'b10001; s_rw[6] = 1'b1;
    s_op[7] = 7'b0010011; s_f3[7] = 3'b101; s_b5[7] = 1'b1; s_b0[7] = 1'b0; s_alu[7] = 5'b10110; s_rw[7] = 1'b1;

    // Output must still show the previous instruction until the next edge.
    check("stream_prev", 32'(ALUControl), 32'(5'b00000));
    for (int i = 0; i < 8; i++) begin
      drive(s_op[i], s_f3[i], s_b5[i], s_b0[i]);
      if (i > 0) check($sformatf("stream_hold%0d", i), 32'(ALUControl), 32'(s_alu[i-1]));
      @(posedge clk);
      #1;
      check($sformatf("stream_alu%0d", i), 32'(ALUControl), 32'(s_alu[i]));
      check($sformatf("stream_rw%0d", i),  32'(RegWrite),   32'(s_rw[i]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
